// File: rtl/ftdi_pkg.sv
// Shared state encoding and default bus timing for the FT2232H async 245 FIFO bridge.
// The timing defaults assume a 66 MHz in_clk.
package ftdi_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RX_STROBE = 3'd1,
    RX_HSK    = 3'd2,
    TX_SETUP  = 3'd3,
    TX_STROBE = 3'd4,
    TX_HSK    = 3'd5,
    GAP       = 3'd6
  } ftdi_state_e;

  localparam int DEF_RD_CYCLES    = 3;
  localparam int DEF_WR_CYCLES    = 3;
  localparam int DEF_SETUP_CYCLES = 1;
  localparam int DEF_GAP_CYCLES   = 3;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int CNT_W            = 8;

endpackage

// File: rtl/ftdi_sync.sv
// Multi-flop synchronizer that brings an asynchronous FTDI status flag into the in_clk domain.
// The chain clears on a synchronous active-high reset.
module ftdi_sync
  import ftdi_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the asynchronous flag through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/ftdi_controller.sv
// Half-duplex bridge between the FT2232H async 245 FIFO pins and two 4-phase byte handshakes.
// Every output is registered and is decoded from the next state.
module ftdi_controller
  import ftdi_pkg::*;
#(
  parameter int RD_CYCLES    = DEF_RD_CYCLES,
  parameter int WR_CYCLES    = DEF_WR_CYCLES,
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_ftdi_txe,
  input  logic       in_ftdi_rxf,
  inout  wire  [7:0] io_ftdi_data,
  output logic       out_ftdi_wr,
  output logic       out_ftdi_rd,
  input  logic       in_rx_en,
  input  logic       in_tx_hsk_req,
  output logic       out_tx_hsk_ack,
  input  logic [7:0] in_tx_data,
  output logic [7:0] out_rx_data,
  output logic       out_rx_hsk_req,
  input  logic       in_rx_hsk_ack
);

  localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  ftdi_state_e      state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic [7:0]       tx_data_r;
  logic             drive_r;
  logic             rxf_s, txe_s;

  ftdi_sync #(.STAGES(SYNC_STAGES)) u_sync_rxf (
    .clk (in_clk),
    .rst (in_rst),
    .d   (in_ftdi_rxf),
    .q   (rxf_s)
  );

  ftdi_sync #(.STAGES(SYNC_STAGES)) u_sync_txe (
    .clk (in_clk),
    .rst (in_rst),
    .d   (in_ftdi_txe),
    .q   (txe_s)
  );

  assign io_ftdi_data = drive_r ? tx_data_r : 8'hzz;

  // Next-state selection and per-state cycle counting.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r + CNT_W'(1);
    case (state_r)
      IDLE: begin
        if (in_rx_en && rxf_s && !out_rx_hsk_req && !in_rx_hsk_ack) begin
          state_nx_s = RX_STROBE;
        end else if (in_tx_hsk_req && txe_s && !out_tx_hsk_ack) begin
          state_nx_s = TX_SETUP;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RX_STROBE: begin
        if (cnt_r == RD_LAST) state_nx_s = RX_HSK;
        else                  state_nx_s = RX_STROBE;
      end
      RX_HSK: begin
        if (in_rx_hsk_ack) state_nx_s = GAP;
        else               state_nx_s = RX_HSK;
      end
      TX_SETUP: begin
        if (cnt_r == SETUP_LAST) state_nx_s = TX_STROBE;
        else                     state_nx_s = TX_SETUP;
      end
      TX_STROBE: begin
        if (cnt_r == WR_LAST) state_nx_s = TX_HSK;
        else                  state_nx_s = TX_STROBE;
      end
      TX_HSK: begin
        if (!in_tx_hsk_req) state_nx_s = GAP;
        else                state_nx_s = TX_HSK;
      end
      GAP: begin
        if (cnt_r == GAP_LAST) state_nx_s = IDLE;
        else                   state_nx_s = GAP;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
    if (state_nx_s != state_r) begin
      cnt_nx_s = '0;
    end else begin
      cnt_nx_s = cnt_r + CNT_W'(1);
    end
  end

  // State, counter and registered pin/handshake outputs; the RX byte is taken as rd ends.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_r        <= IDLE;
      cnt_r          <= '0;
      tx_data_r      <= 8'h00;
      drive_r        <= 1'b0;
      out_ftdi_rd    <= 1'b0;
      out_ftdi_wr    <= 1'b0;
      out_rx_hsk_req <= 1'b0;
      out_tx_hsk_ack <= 1'b0;
      out_rx_data    <= 8'h00;
    end else begin
      state_r        <= state_nx_s;
      cnt_r          <= cnt_nx_s;
      drive_r        <= (state_nx_s == TX_SETUP) || (state_nx_s == TX_STROBE);
      out_ftdi_rd    <= (state_nx_s == RX_STROBE);
      out_ftdi_wr    <= (state_nx_s == TX_STROBE);
      out_rx_hsk_req <= (state_nx_s == RX_HSK);
      out_tx_hsk_ack <= (state_nx_s == TX_HSK);
      if ((state_r == IDLE) && (state_nx_s == TX_SETUP)) begin
        tx_data_r <= in_tx_data;
      end
      if ((state_r == RX_STROBE) && (state_nx_s == RX_HSK)) begin
        out_rx_data <= io_ftdi_data;
      end
    end
  end

endmodule

// File: tb/tb_ftdi_controller.sv
// Self-checking bench for ftdi_controller: an FT2232H FIFO model on the pins, table vectors,
// hand-written corner sequences and randomized transfers checked against byte-order queues.
module tb_ftdi_controller;

  localparam int RD_LEN = 3;
  localparam int WR_LEN = 3;
  localparam int MAXW   = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ftdi_txe = 1'b0;
  logic       ftdi_rxf = 1'b0;
  logic       rx_en = 1'b0;
  logic       tx_req = 1'b0;
  logic       rx_ack = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire  [7:0] ftdi_bus;
  logic       ftdi_wr, ftdi_rd, tx_ack, rx_req;
  logic [7:0] rx_data;
  logic [7:0] model_head = 8'h00;

  int checks = 0;
  int errors = 0;

  // FTDI side: bus driven only while rd is high, otherwise pulled high.
  logic [7:0] rx_q[$];
  logic [7:0] tx_cap_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_tx_q[$];
  logic       prev_rd = 1'b0, prev_wr = 1'b0;
  logic [7:0] prev_bus = 8'hFF;
  logic [7:0] last_setup_bus = 8'h00;
  int rd_run = 0, wr_run = 0, last_rd_len = 0, last_wr_len = 0;
  int rd_pulses = 0, wr_pulses = 0;

  assign ftdi_bus = ftdi_rd ? model_head : 8'hzz;
  pullup pu_bus (ftdi_bus);

  always #5 clk = ~clk;

  ftdi_controller dut (
    .in_clk         (clk),
    .in_rst         (rst),
    .in_ftdi_txe    (ftdi_txe),
    .in_ftdi_rxf    (ftdi_rxf),
    .io_ftdi_data   (ftdi_bus),
    .out_ftdi_wr    (ftdi_wr),
    .out_ftdi_rd    (ftdi_rd),
    .in_rx_en       (rx_en),
    .in_tx_hsk_req  (tx_req),
    .out_tx_hsk_ack (tx_ack),
    .in_tx_data     (tx_data),
    .out_rx_data    (rx_data),
    .out_rx_hsk_req (rx_req),
    .in_rx_hsk_ack  (rx_ack)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return rx_req;
      1:       return tx_ack;
      2:       return ftdi_rd;
      default: return ftdi_wr;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int which, input logic val);
    int n;
    n = 0;
    while (sel(which) !== val && n < MAXW) begin
      step();
      n++;
    end
    check({name, "_timeout"}, 32'(n < MAXW), 32'd1);
  endtask

  // FTDI model and pin-level monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (ftdi_rd === 1'b1 || ftdi_wr === 1'b1) begin
      check("strobe_overlap", {29'd0, ftdi_rd & ftdi_wr, ftdi_rd & prev_wr, ftdi_wr & prev_rd}, 32'd0);
    end
    if (ftdi_rd === 1'b1 && prev_rd !== 1'b1) begin
      check("bus_during_rd", {24'd0, ftdi_bus}, {24'd0, model_head});
    end
    if (ftdi_wr === 1'b1 && prev_wr !== 1'b1) begin
      last_setup_bus = prev_bus;
      tx_cap_q.push_back(ftdi_bus);
    end
    if (ftdi_rd === 1'b1) begin
      rd_run++;
    end else if (prev_rd === 1'b1) begin
      last_rd_len = rd_run;
      rd_run = 0;
      rd_pulses++;
      if (rx_q.size() > 0) void'(rx_q.pop_front());
    end
    if (ftdi_wr === 1'b1) begin
      wr_run++;
    end else if (prev_wr === 1'b1) begin
      last_wr_len = wr_run;
      wr_run = 0;
      wr_pulses++;
    end
    if (ftdi_rd !== 1'b1) model_head = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    ftdi_rxf = (rx_q.size() != 0);
    prev_rd  = ftdi_rd;
    prev_wr  = ftdi_wr;
    prev_bus = ftdi_bus;
  end

  task automatic rx_one(input logic [7:0] b, input int ack_dly, input int exp_len);
    int p0;
    p0 = rd_pulses;
    rx_q.push_back(b);
    exp_rx_q.push_back(b);
    rx_en = 1'b1;
    wait_sig("rx_req", 0, 1'b1);
    @(negedge clk);
    #1;
    check("rx_rd_len", 32'(last_rd_len), 32'(exp_len));
    check("rx_rd_count", 32'(rd_pulses - p0), 32'd1);
    check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
    check("rx_bus_released", {24'd0, ftdi_bus}, 32'h0000_00FF);
    for (int i = 0; i < ack_dly; i++) begin
      step();
      check("rx_req_hold", {31'd0, rx_req}, 32'd1);
      check("rx_data_hold", {24'd0, rx_data}, {24'd0, b});
    end
    rx_ack = 1'b1;
    step();
    check("rx_req_drop", {31'd0, rx_req}, 32'd0);
    rx_ack = 1'b0;
    step();
  endtask

  task automatic tx_one(input logic [7:0] b, input int txe_dly, input int exp_len);
    int p0;
    p0 = wr_pulses;
    exp_tx_q.push_back(b);
    if (txe_dly > 0) begin
      ftdi_txe = 1'b0;
      repeat (3) step();
    end
    tx_data = b;
    tx_req  = 1'b1;
    if (txe_dly > 0) begin
      repeat (txe_dly) step();
      check("tx_stall_no_wr", 32'(wr_pulses - p0 + wr_run), 32'd0);
      ftdi_txe = 1'b1;
    end
    wait_sig("tx_ack", 1, 1'b1);
    @(negedge clk);
    #1;
    check("tx_wr_len", 32'(last_wr_len), 32'(exp_len));
    check("tx_wr_count", 32'(wr_pulses - p0), 32'd1);
    check("tx_setup_bus", {24'd0, last_setup_bus}, {24'd0, b});
    check("tx_cap_count", 32'(tx_cap_q.size()), 32'd1);
    if (tx_cap_q.size() > 0) check("tx_byte", {24'd0, tx_cap_q.pop_front()}, {24'd0, exp_tx_q[0]});
    void'(exp_tx_q.pop_front());
    tx_cap_q.delete();
    check("tx_bus_released", {24'd0, ftdi_bus}, 32'h0000_00FF);
    repeat (2) step();
    check("tx_ack_hold", {31'd0, tx_ack}, 32'd1);
    tx_req = 1'b0;
    step();
    check("tx_ack_drop", {31'd0, tx_ack}, 32'd0);
  endtask

  typedef struct {
    logic       is_tx;
    logic [7:0] data;
    int         delay;
    int         exp_len;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int p0;
    logic seen;

    vecs[0] = '{1'b0, 8'hA5, 0, RD_LEN};
    vecs[1] = '{1'b0, 8'h5A, 2, RD_LEN};
    vecs[2] = '{1'b0, 8'hFF, 1, RD_LEN};
    vecs[3] = '{1'b0, 8'h00, 0, RD_LEN};
    vecs[4] = '{1'b1, 8'h3C, 0, WR_LEN};
    vecs[5] = '{1'b1, 8'hC3, 20, WR_LEN};
    vecs[6] = '{1'b1, 8'h81, 0, WR_LEN};

    // Reset held for four cycles.
    repeat (4) step();
    check("rst_rd", {31'd0, ftdi_rd}, 32'd0);
    check("rst_wr", {31'd0, ftdi_wr}, 32'd0);
    check("rst_rx_req", {31'd0, rx_req}, 32'd0);
    check("rst_tx_ack", {31'd0, tx_ack}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_bus", {24'd0, ftdi_bus}, 32'h0000_00FF);
    rst = 1'b0;
    repeat (10) step();
    check("idle_no_rd", 32'(rd_pulses), 32'd0);
    check("idle_no_wr", 32'(wr_pulses), 32'd0);
    check("idle_bus", {24'd0, ftdi_bus}, 32'h0000_00FF);
    ftdi_txe = 1'b1;

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].is_tx) tx_one(vecs[i].data, vecs[i].delay, vecs[i].exp_len);
      else               rx_one(vecs[i].data, vecs[i].delay, vecs[i].exp_len);
    end

    // rx_en low blocks reads while rxf is up.
    rx_en = 1'b0;
    p0 = rd_pulses;
    rx_q.push_back(8'h77);
    repeat (50) step();
    check("rx_en_gate", 32'(rd_pulses - p0 + rd_run), 32'd0);
    rx_q.delete();
    repeat (6) step();

    // RX and TX pending together: RX first, then TX after the gap.
    rx_q.push_back(8'h96);
    exp_rx_q.push_back(8'h96);
    repeat (5) step();
    p0 = wr_pulses;
    tx_data = 8'h69;
    tx_req  = 1'b1;
    rx_en   = 1'b1;
    exp_tx_q.push_back(8'h69);
    wait_sig("both_rx_req", 0, 1'b1);
    @(negedge clk);
    #1;
    check("both_rx_first", 32'(wr_pulses - p0 + wr_run), 32'd0);
    check("both_rx_data", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
    rx_ack = 1'b1;
    step();
    rx_ack = 1'b0;
    wait_sig("both_tx_ack", 1, 1'b1);
    @(negedge clk);
    #1;
    check("both_tx_count", 32'(wr_pulses - p0), 32'd1);
    check("both_tx_cap", 32'(tx_cap_q.size()), 32'd1);
    if (tx_cap_q.size() > 0) check("both_tx_byte", {24'd0, tx_cap_q.pop_front()}, {24'd0, exp_tx_q[0]});
    void'(exp_tx_q.pop_front());
    tx_cap_q.delete();
    tx_req = 1'b0;
    step();
    check("both_tx_ack_drop", {31'd0, tx_ack}, 32'd0);
    repeat (6) step();

    // Reset during the second rd cycle.
    rx_q.push_back(8'hE1);
    wait_sig("mid_rd", 2, 1'b1);
    step();
    rst = 1'b1;
    rx_en = 1'b0;
    step();
    check("rst_rd_drop", {31'd0, ftdi_rd}, 32'd0);
    check("rst_rd_bus", {24'd0, ftdi_bus}, 32'h0000_00FF);
    check("rst_rd_req", {31'd0, rx_req}, 32'd0);
    rst = 1'b0;
    rx_q.delete();
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      seen = seen | rx_req;
    end
    check("rst_rd_no_req", {31'd0, seen}, 32'd0);

    // Reset during TX_STROBE.
    tx_data = 8'h4B;
    tx_req  = 1'b1;
    wait_sig("mid_wr", 3, 1'b1);
    rst = 1'b1;
    tx_req = 1'b0;
    step();
    check("rst_wr_drop", {31'd0, ftdi_wr}, 32'd0);
    check("rst_wr_bus", {24'd0, ftdi_bus}, 32'h0000_00FF);
    check("rst_wr_ack", {31'd0, tx_ack}, 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      seen = seen | tx_ack;
    end
    check("rst_wr_no_ack", {31'd0, seen}, 32'd0);
    tx_cap_q.delete();

    // Randomized transfers checked against the ordered byte queues.
    for (int i = 0; i < 20; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 0) rx_one(b, $urandom_range(0, 4), RD_LEN);
      else tx_one(b, ($urandom_range(0, 1) == 1) ? $urandom_range(4, 12) : 0, WR_LEN);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
